alu_bist_sequencer: RTL and testbench
=====================================

// Module: alu_bist_sequencer
// PURPOSE
//  Hardware self-test driver for the 32-bit ALU. It plays the testbench's role in silicon:
//  - walks a loadable table of vectors {operandA, operandB, command, expected result, expected flags};
//  - drives each vector into the ALU, waits a settle time and compares the ALU outputs;
//  - reports pass/fail and fail statistics.
//  It sits beside the ALU, with its operand/command outputs muxed onto the ALU inputs in test mode.
// PARAMETERS
//  DEPTH      16  number of vector table entries
//  ADDR_W     4   table index width, clog2(DEPTH)
//  SETTLE     2   cycles waited after applying a vector before sampling the ALU (>=1)
//  CNT_W      8   fail counter width
// PORTS
//  clk               in   1       single clock, all state on rising edge
//  reset             in   1       synchronous, active-high
//  vec_we            in   1       table write strobe (honoured only in IDLE)
//  vec_addr          in   ADDR_W  table write index
//  vec_wdata         in   105     {a[31:0], b[31:0], cmd[2:0], exp_res[31:0], exp_flags[2:0], flag_mask[2:0]}
//  start             in   1       begin run (honoured only in IDLE)
//  run_len           in   ADDR_W+1  number of vectors to run, sampled with start, 0..DEPTH
//  alu_operandA      out  32      registered ALU operand A
//  alu_operandB      out  32      registered ALU operand B
//  alu_command       out  3       registered ALU command
//  alu_result        in   32      ALU result
//  alu_carryout      in   1       ALU carryout
//  alu_zero          in   1       ALU zero
//  alu_overflow      in   1       ALU overflow
//  busy              out  1       high in APPLY/WAIT/CHECK
//  done              out  1       one-cycle pulse when a run completes
//  pass              out  1       1 if last run had zero failures; held until next start
//  fail_count        out  CNT_W   failures in current/last run, saturating at 2^CNT_W-1
//  first_fail_idx    out  ADDR_W  index of first failing vector; valid when fail_count!=0
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (alu_command=0=ADD); idx, settle counter cleared.
//    Table contents are NOT cleared.
//  - FSM states:
//    - IDLE:  start -> load run_len, idx=0, fail_count=0, pass=0.
//             run_len==0 -> DONE; else -> APPLY.
//    - APPLY: load alu_operandA/B/command from table[idx] (registered); -> WAIT.
//    - WAIT:  stay SETTLE cycles; -> CHECK.
//    - CHECK: mismatch = (alu_result!=exp_res) | (({carryout,zero,overflow}^exp_flags) & flag_mask).
//             On mismatch: fail_count++ (saturate); if it was 0, first_fail_idx=idx.
//             idx==run_len-1 -> DONE; else idx++ and -> APPLY.
//    - DONE:  done=1 for this cycle only; pass=(fail_count==0); -> IDLE.
//  - Latency: start seen in cycle 0; done high in cycle 1+run_len*(2+SETTLE); run_len=0 -> cycle 1.
//  - A fail_count==0 compare uses pre-increment value. Saturation keeps first_fail_idx unchanged.
//  - Table writes:
//    - vec_we outside IDLE is ignored, so the table is stable for a whole run.
//    - A write and a start in the same IDLE cycle: the write lands; the run reads the new entry.
//  - start outside IDLE is ignored. run_len>DEPTH is clamped to DEPTH.
//  - ALU operand registers keep the last vector after a run (no return to 0) until reset.
//  - Reset mid-run: next cycle IDLE; outputs as at reset; done not pulsed; pass=0.
//  - Flag ordering everywhere: bit2=carryout, bit1=zero, bit0=overflow.
// STRUCTURE
//  - Shared include (alu_defs): 3-bit ALU command codes ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5
//    NOR=6 OR=7; FLAG_* bit positions; vector field offsets/width (105).
//    Used by both the ALU and this block.
//  - One sub-module, bist_vector_ram: DEPTH x 105 register array, synchronous write,
//    combinational read.
//  - FSM, settle counter and compare/stats logic live in the top module.
// TESTING
//  1. Vec0 a=7FFFFFFF b=1 ADD exp=80000000 flags=001 mask=111, run_len=1
//     -> done at cycle 1+(2+SETTLE), pass=1, fail_count=0.
//  2. Vecs {3-1 SUB exp 2 flags 000}, {FFFF0000 AND 00FF00FF exp 0000FFFF (wrong, true 00FF0000)}, run_len=2
//     -> pass=0, fail_count=1, first_fail_idx=1.
//  3. SLT 555555AA<55AA55AA exp=1 mask=000 with bogus exp_flags=111 -> pass=1 (flags masked).
//  4. run_len=0 start -> done pulse in cycle 1, pass=1, ALU outputs unchanged.
//  5. While busy: vec_we to idx0 and a second start -> both ignored; table[0] readback and run result unchanged.
//  6. reset asserted during WAIT of vector 3 of 5
//     -> IDLE next cycle, all outputs 0, no done; then a fresh start runs all 5 from idx0.

Source files
------------

// File: rtl/alu_bist_sequencer_pkg.sv
// Shared ALU definitions: command codes, flag bit positions and the BIST vector layout.
// Used by both the ALU and its self-test sequencer.
package alu_bist_sequencer_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 3;
  localparam int FLAG_W = 3;
  localparam int VEC_W  = 105;

  typedef enum logic [CMD_W-1:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_SLT  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_NOR  = 3'd6,
    ALU_OR   = 3'd7
  } alu_cmd_e;

  localparam int FLAG_CARRY = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_OVF   = 0;

  // Vector layout, MSB first: {a, b, cmd, exp_res, exp_flags, flag_mask}
  localparam int VEC_MASK_LSB  = 0;
  localparam int VEC_FLAGS_LSB = VEC_MASK_LSB + FLAG_W;
  localparam int VEC_RES_LSB   = VEC_FLAGS_LSB + FLAG_W;
  localparam int VEC_CMD_LSB   = VEC_RES_LSB + DATA_W;
  localparam int VEC_B_LSB     = VEC_CMD_LSB + CMD_W;
  localparam int VEC_A_LSB     = VEC_B_LSB + DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } bist_state_e;

endpackage

// File: rtl/bist_vector_ram.sv
// BIST vector table: register array with synchronous write and combinational read.
module bist_vector_ram
  import alu_bist_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [VEC_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [VEC_W-1:0]  rdata_o
);

  logic [VEC_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; loaded vectors survive a reset of the sequencer.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_bist_sequencer.sv
// ALU self-test sequencer: walks the vector table, drives the ALU, waits SETTLE cycles,
// compares result and masked flags, and reports pass / fail statistics.
module alu_bist_sequencer
  import alu_bist_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              vec_we_i,
  input  logic [ADDR_W-1:0] vec_addr_i,
  input  logic [VEC_W-1:0]  vec_wdata_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   run_len_i,
  output logic [DATA_W-1:0] alu_operandA_o,
  output logic [DATA_W-1:0] alu_operandB_o,
  output logic [CMD_W-1:0]  alu_command_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_carryout_i,
  input  logic              alu_zero_i,
  input  logic              alu_overflow_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [CNT_W-1:0]  fail_count_o,
  output logic [ADDR_W-1:0] first_fail_idx_o
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  bist_state_e       state_q;
  logic [ADDR_W-1:0] idx_q, last_q, first_q;
  logic [SET_W-1:0]  settle_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [CMD_W-1:0]  cmd_q;
  logic              busy_q, done_q, pass_q;
  logic [CNT_W-1:0]  fail_q, fail_d;

  logic [VEC_W-1:0]  rd_vec;
  logic [DATA_W-1:0] vec_a, vec_b, vec_res;
  logic [CMD_W-1:0]  vec_cmd;
  logic [FLAG_W-1:0] vec_flags, vec_mask, obs_flags;
  logic [ADDR_W:0]   run_len_clamped;
  logic              mismatch;

  // Writes are gated to IDLE so the table cannot change underneath a run.
  bist_vector_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk_i   (clk_i),
    .we_i    (vec_we_i && (state_q == ST_IDLE)),
    .waddr_i (vec_addr_i),
    .wdata_i (vec_wdata_i),
    .raddr_i (idx_q),
    .rdata_o (rd_vec)
  );

  assign vec_a     = rd_vec[VEC_A_LSB     +: DATA_W];
  assign vec_b     = rd_vec[VEC_B_LSB     +: DATA_W];
  assign vec_cmd   = rd_vec[VEC_CMD_LSB   +: CMD_W];
  assign vec_res   = rd_vec[VEC_RES_LSB   +: DATA_W];
  assign vec_flags = rd_vec[VEC_FLAGS_LSB +: FLAG_W];
  assign vec_mask  = rd_vec[VEC_MASK_LSB  +: FLAG_W];

  assign run_len_clamped = (run_len_i > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : run_len_i;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    obs_flags             = '0;
    obs_flags[FLAG_CARRY] = alu_carryout_i;
    obs_flags[FLAG_ZERO]  = alu_zero_i;
    obs_flags[FLAG_OVF]   = alu_overflow_i;
  end

  assign mismatch = (alu_result_i != vec_res) || (((obs_flags ^ vec_flags) & vec_mask) != '0);
  assign fail_d   = (mismatch && (fail_q != '1)) ? fail_q + 1'b1 : fail_q;

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      first_q  <= '0;
      settle_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cmd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            idx_q  <= '0;
            fail_q <= '0;
            last_q <= ADDR_W'(run_len_clamped - 1'b1);
            if (run_len_clamped == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= ST_APPLY;
              busy_q  <= 1'b1;
              pass_q  <= 1'b0;
            end
          end
        end
        ST_APPLY: begin
          a_q      <= vec_a;
          b_q      <= vec_b;
          cmd_q    <= vec_cmd;
          settle_q <= SET_W'(SETTLE - 1);
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (settle_q == '0) state_q <= ST_CHECK;
          else                settle_q <= settle_q - 1'b1;
        end
        ST_CHECK: begin
          fail_q <= fail_d;
          if (mismatch && (fail_q == '0)) first_q <= idx_q;
          if (idx_q == last_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (fail_d == '0);
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ST_APPLY;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_operandA_o   = a_q;
  assign alu_operandB_o   = b_q;
  assign alu_command_o    = cmd_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign fail_count_o     = fail_q;
  assign first_fail_idx_o = first_q;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Self-checking bench for alu_bist_sequencer: behavioural ALU plus a run-result scoreboard.
module tb_alu_bist_sequencer;
  import alu_bist_sequencer_pkg::*;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int SETTLE  = 2;
  localparam int CNT_W   = 8;
  localparam int PER_VEC = 2 + SETTLE;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              vec_we = 1'b0;
  logic [ADDR_W-1:0] vec_addr = '0;
  logic [VEC_W-1:0]  vec_wdata = '0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   run_len = '0;
  logic [31:0]       alu_operandA, alu_operandB, alu_result;
  logic [2:0]        alu_command;
  logic              alu_carryout, alu_zero, alu_overflow;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  fail_count;
  logic [ADDR_W-1:0] first_fail_idx;

  alu_bist_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(reset), .vec_we_i(vec_we), .vec_addr_i(vec_addr),
    .vec_wdata_i(vec_wdata), .start_i(start), .run_len_i(run_len),
    .alu_operandA_o(alu_operandA), .alu_operandB_o(alu_operandB), .alu_command_o(alu_command),
    .alu_result_i(alu_result), .alu_carryout_i(alu_carryout), .alu_zero_i(alu_zero),
    .alu_overflow_i(alu_overflow), .busy_o(busy), .done_o(done), .pass_o(pass),
    .fail_count_o(fail_count), .first_fail_idx_o(first_fail_idx)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Returns {carry, zero, overflow, result}.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] cmd);
    logic [32:0] sum;
    logic [31:0] r;
    logic        c, v;
    sum = '0; r = '0; c = 1'b0; v = 1'b0;
    case (cmd)
      3'd0: begin sum = {1'b0, a} + {1'b0, b};         r = sum[31:0]; c = sum[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin sum = {1'b0, a} + {1'b0, ~b} + 33'd1; r = sum[31:0]; c = sum[32];
                  v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {c, (r == 32'd0), v, r};
  endfunction

  always_comb {alu_carryout, alu_zero, alu_overflow, alu_result} =
    alu_model(alu_operandA, alu_operandB, alu_command);

  function automatic logic [VEC_W-1:0] pack_vec(input logic [31:0] a, input logic [31:0] b,
      input logic [2:0] cmd, input logic [31:0] res, input logic [2:0] fl, input logic [2:0] mk);
    return {a, b, cmd, res, fl, mk};
  endfunction

  typedef struct {
    int unsigned       cycle;
    logic              pass;
    logic [CNT_W-1:0]  fails;
    logic [ADDR_W-1:0] first;
    logic [31:0]       a, b;
    logic [2:0]        cmd;
  } exp_t;

  exp_t             sb_q[$];
  logic [VEC_W-1:0] shadow [DEPTH];
  logic [31:0]      last_a = '0, last_b = '0;
  logic [2:0]       last_cmd = '0;
  int               errors = 0;
  int               checks = 0;

  task automatic push_expected(input int len, input int unsigned start_cyc);
    exp_t        e;
    int          n;
    logic [31:0] a, b, res, mr;
    logic [2:0]  cmd, fl, mk, mf;
    n = (len > DEPTH) ? DEPTH : len;
    e.fails = '0;
    e.first = '0;
    for (int i = 0; i < n; i++) begin
      {a, b, cmd, res, fl, mk} = shadow[i];
      {mf, mr} = alu_model(a, b, cmd);
      if ((mr !== res) || (((mf ^ fl) & mk) !== 3'b000)) begin
        if (e.fails == '0) e.first = ADDR_W'(i);
        if (e.fails != '1) e.fails = e.fails + 1'b1;
      end
    end
    if (n > 0) {last_a, last_b, last_cmd} = shadow[n-1][VEC_W-1 -: 67];
    e.a = last_a; e.b = last_b; e.cmd = last_cmd;
    e.pass  = (e.fails == '0);
    e.cycle = start_cyc + 1 + n * PER_VEC;
    sb_q.push_back(e);
  endtask

  task automatic write_vec(input int idx, input logic [VEC_W-1:0] v);
    @(posedge clk); #1;
    vec_we = 1'b1; vec_addr = ADDR_W'(idx); vec_wdata = v;
    shadow[idx] = v;
    @(posedge clk); #1;
    vec_we = 1'b0;
  endtask

  // Issues start (optionally with a same-cycle table write) and returns in cycle 1 of the run.
  task automatic start_run(input int len, input bit wr, input int widx, input logic [VEC_W-1:0] wv);
    @(posedge clk); #1;
    start = 1'b1; run_len = (ADDR_W+1)'(len);
    if (wr) begin
      vec_we = 1'b1; vec_addr = ADDR_W'(widx); vec_wdata = wv; shadow[widx] = wv;
    end
    push_expected(len, cyc);
    @(posedge clk); #1;
    start = 1'b0; vec_we = 1'b0;
    checks++;
    if (busy !== (len != 0)) begin
      errors++; $display("FAIL start_busy: got %b expected %b", busy, (len != 0));
    end
    checks++;
    if (pass !== (len == 0)) begin
      errors++; $display("FAIL start_pass: got %b expected %b", pass, (len == 0));
    end
  endtask

  task automatic wait_done(input string name);
    exp_t e;
    int   budget;
    budget = 0;
    while (done !== 1'b1 && budget < 200) begin
      @(posedge clk); #1; budget++;
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
      return;
    end
    e = sb_q.pop_front();
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s_timeout: got no done expected done at cycle %0d", name, e.cycle);
      return;
    end
    checks++;
    if (cyc !== e.cycle) begin
      errors++; $display("FAIL %s_latency: got cycle %0d expected %0d", name, cyc, e.cycle);
    end
    checks++;
    if (pass !== e.pass) begin
      errors++; $display("FAIL %s_pass: got %b expected %b", name, pass, e.pass);
    end
    checks++;
    if (fail_count !== e.fails) begin
      errors++; $display("FAIL %s_fail_count: got %0d expected %0d", name, fail_count, e.fails);
    end
    if (e.fails != '0) begin
      checks++;
      if (first_fail_idx !== e.first) begin
        errors++; $display("FAIL %s_first_idx: got %0d expected %0d", name, first_fail_idx, e.first);
      end
    end
    checks++;
    if ({busy, alu_operandA, alu_operandB, alu_command} !== {1'b0, e.a, e.b, e.cmd}) begin
      errors++;
      $display("FAIL %s_alu_out: got busy=%b a=%h b=%h cmd=%0d expected busy=0 a=%h b=%h cmd=%0d",
               name, busy, alu_operandA, alu_operandB, alu_command, e.a, e.b, e.cmd);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, pass} !== {1'b0, e.pass}) begin
      errors++; $display("FAIL %s_pulse: got done=%b pass=%b expected done=0 pass=%b",
                         name, done, pass, e.pass);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({busy, done, pass, fail_count, first_fail_idx, alu_operandA, alu_operandB, alu_command} !== '0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b pass=%b fc=%0d ffi=%0d a=%h b=%h cmd=%0d expected all zero",
               name, busy, done, pass, fail_count, first_fail_idx, alu_operandA, alu_operandB, alu_command);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_single_add();
    write_vec(0, pack_vec(32'h7FFFFFFF, 32'h1, 3'd0, 32'h80000000, 3'b001, 3'b111));
    start_run(1, 1'b0, 0, '0);
    wait_done("single_add");
  endtask

  task automatic test_two_vec_fail();
    write_vec(0, pack_vec(32'd3, 32'd1, 3'd1, 32'd2, 3'b000, 3'b011));
    write_vec(1, pack_vec(32'hFFFF0000, 32'h00FF00FF, 3'd4, 32'h0000FFFF, 3'b000, 3'b111));
    start_run(2, 1'b0, 0, '0);
    wait_done("two_vec_fail");
  endtask

  task automatic test_masked_flags_with_write();
    // The SLT vector is written in the same cycle as start; the run must see it.
    start_run(1, 1'b1, 0, pack_vec(32'h555555AA, 32'h55AA55AA, 3'd3, 32'd1, 3'b111, 3'b000));
    wait_done("masked_flags");
  endtask

  task automatic test_zero_len();
    start_run(0, 1'b0, 0, '0);
    wait_done("zero_len");
  endtask

  task automatic test_busy_ignore();
    write_vec(0, pack_vec(32'd1, 32'd2, 3'd0, 32'd3, 3'b000, 3'b111));
    write_vec(1, pack_vec(32'h0F0F, 32'h00FF, 3'd2, 32'h0FF0, 3'b000, 3'b111));
    write_vec(2, pack_vec(32'hF000000F, 32'h0F0000F0, 3'd7, 32'hFF0000FF, 3'b000, 3'b111));
    start_run(3, 1'b0, 0, '0);
    @(posedge clk); #1;
    vec_we = 1'b1; vec_addr = '0; vec_wdata = pack_vec(32'd1, 32'd2, 3'd0, 32'hBAD, 3'b000, 3'b111);
    start = 1'b1; run_len = 5'd1;
    @(posedge clk); #1;
    vec_we = 1'b0; start = 1'b0;
    wait_done("busy_run");
    start_run(1, 1'b0, 0, '0);
    wait_done("busy_reread");
  endtask

  task automatic test_clamp_random();
    logic [31:0] a, b, mr;
    logic [2:0]  cmd, mf;
    for (int i = 0; i < DEPTH; i++) begin
      a = $urandom; b = $urandom; cmd = 3'($urandom_range(0, 7));
      if (i == 4) b = a;
      {mf, mr} = alu_model(a, b, cmd);
      if (i % 5 == 2) mr = mr ^ 32'h1;
      if (i == 9)     mf = mf ^ 3'b010;
      write_vec(i, pack_vec(a, b, cmd, mr, mf, 3'b111));
    end
    start_run(20, 1'b0, 0, '0);
    wait_done("clamp_random");
  endtask

  task automatic test_reset_mid_run();
    int seen;
    start_run(5, 1'b0, 0, '0);
    repeat (9) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midrun_busy: got %b expected 1", busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    last_a = '0; last_b = '0; last_cmd = '0;
    check_reset_outputs("midrun_reset_state");
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrun_no_done: got %0d done pulses expected 0", seen);
    end
    start_run(5, 1'b0, 0, '0);
    wait_done("midrun_rerun");
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_two_vec_fail();
    test_masked_flags_with_write();
    test_zero_len();
    test_busy_ignore();
    test_clamp_random();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
